// File: rtl/note_sequencer.sv
// Step sequencer: plays a STEPS-entry {wave, freq} pattern, one step per TICK_DIV clocks.
// Optional macro SEQ_GAP_EN adds a silent GAP of GAP_CYC cycles at the end of each step.
module note_sequencer #(
  parameter int STEPS    = 8,
  parameter int TICK_DIV = 25000000,
  parameter int GAP_CYC  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [11:0]              wr_freq,
  input  logic [3:0]               wr_wave,
  output logic [11:0]              freq,
  output logic [3:0]               wave_en,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     playing,
  output logic                     step_pulse
);

  localparam int AW = $clog2(STEPS);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if ((TICK_DIV < 4) || (GAP_CYC >= TICK_DIV) || (STEPS < 2) || (STEPS > 16) ||
      ((STEPS & (STEPS - 1)) != 0)) begin : g_bad_cfg
    $error("note_sequencer: invalid parameter set");
  end

`ifdef SEQ_GAP_EN
  localparam logic [TW-1:0] GAP_PRE = TW'(TICK_DIV - GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;
`endif

  // A step whose freq field is zero is a rest: both fields are silenced.
  function automatic logic [15:0] note_mask(input logic [15:0] entry);
    if (entry[11:0] == 12'd0) begin
      note_mask = 16'd0;
    end else begin
      note_mask = entry;
    end
  endfunction

  logic [15:0]   pattern_r [STEPS];
  state_t        state_r, state_s;
  logic [TW-1:0] tick_r, tick_s;
  logic [AW-1:0] step_r, step_s, step_inc_s;
  logic [11:0]   freq_r, freq_s;
  logic [3:0]    wave_r, wave_s;
  logic          playing_r, playing_s;
  logic          pulse_r, pulse_s;
  logic          tick_end_s;

  assign tick_end_s = (tick_r == TICK_LAST);
  assign step_inc_s = step_r + AW'(1);

  // Pattern storage; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) pattern_r[i] <= 16'd0;
    end else if (wr_en) begin
      pattern_r[wr_addr] <= {wr_wave, wr_freq};
    end else begin
      pattern_r[wr_addr] <= pattern_r[wr_addr];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      tick_r    <= {TW{1'b0}};
      step_r    <= {AW{1'b0}};
      freq_r    <= 12'd0;
      wave_r    <= 4'd0;
      playing_r <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      tick_r    <= tick_s;
      step_r    <= step_s;
      freq_r    <= freq_s;
      wave_r    <= wave_s;
      playing_r <= playing_s;
      pulse_r   <= pulse_s;
    end
  end

  // Next state: stop beats start, start beats the step timer.
  always_comb begin
    state_s = state_r;
    if (stop) begin
      state_s = IDLE;
    end else if (start) begin
      state_s = PLAY;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
`ifdef SEQ_GAP_EN
        PLAY: begin
          if (!tick_end_s && (tick_r == GAP_PRE)) state_s = GAP;
          else state_s = PLAY;
        end
        GAP: begin
          if (tick_end_s) state_s = PLAY;
          else state_s = GAP;
        end
`else
        PLAY: state_s = PLAY;
`endif
        default: state_s = IDLE;
      endcase
    end
  end

  // Next output values; notes load only on step entry so in-flight writes wait.
  always_comb begin
    tick_s    = tick_r;
    step_s    = step_r;
    freq_s    = freq_r;
    wave_s    = wave_r;
    pulse_s   = 1'b0;
    playing_s = (state_s != IDLE);
    if (stop || (state_r == IDLE && !start)) begin
      tick_s = {TW{1'b0}};
      step_s = {AW{1'b0}};
      freq_s = 12'd0;
      wave_s = 4'd0;
    end else if (start) begin
      tick_s           = {TW{1'b0}};
      step_s           = {AW{1'b0}};
      {wave_s, freq_s} = note_mask(pattern_r[0]);
      pulse_s          = 1'b1;
    end else if (tick_end_s) begin
      tick_s           = {TW{1'b0}};
      step_s           = step_inc_s;
      {wave_s, freq_s} = note_mask(pattern_r[step_inc_s]);
      pulse_s          = 1'b1;
    end else begin
      tick_s = tick_r + TW'(1);
`ifdef SEQ_GAP_EN
      if (state_s == GAP) begin
        freq_s = 12'd0;
        wave_s = 4'd0;
      end else begin
        freq_s = freq_r;
        wave_s = wave_r;
      end
`endif
    end
  end

  assign freq       = freq_r;
  assign wave_en    = wave_r;
  assign step_idx   = step_r;
  assign playing    = playing_r;
  assign step_pulse = pulse_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus random writes,
// compared every cycle against an elapsed-time model of the pattern player.
module tb_note_sequencer;
  localparam int ST = 8;
  localparam int TD = 4;
  localparam int GC = 1;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_freq;
  logic [3:0]  wr_wave;
  logic [11:0] freq;
  logic [3:0]  wave_en;
  logic [2:0]  step_idx;
  logic        playing, step_pulse;

  int checks = 0;
  int errors = 0;

  // Model: pattern copy, playing flag, cycles since last (re)start, note latched on entry.
  logic [15:0] mpat [ST];
  logic [15:0] latch;
  bit          mplay;
  int          e;

  always #5 clk = ~clk;

  note_sequencer #(.STEPS(ST), .TICK_DIV(TD), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_wave(wr_wave),
    .freq(freq), .wave_en(wave_en), .step_idx(step_idx),
    .playing(playing), .step_pulse(step_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      $error("%s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_model();
    logic [15:0] note;
    int          pos;
    note = 16'd0;
    pos  = e % TD;
    if (mplay) begin
      note = (latch[11:0] == 12'd0) ? 16'd0 : latch;
`ifdef SEQ_GAP_EN
      if (pos >= TD - GC) note = 16'd0;
`endif
    end
    check("freq", freq, note[11:0]);
    check("wave_en", wave_en, note[15:12]);
    check("step_idx", step_idx, mplay ? (e / TD) % ST : 0);
    check("playing", playing, mplay);
    check("step_pulse", step_pulse, mplay && pos == 0);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic we,
                     input logic [2:0] wa, input logic [15:0] wd);
    rst_n = r; start = s; stop = p; wr_en = we; wr_addr = wa;
    {wr_wave, wr_freq} = wd;
    @(posedge clk);
    if (!r) begin
      mplay = 1'b0; e = 0;
      for (int i = 0; i < ST; i++) mpat[i] = 16'd0;
    end else begin
      if (p) begin mplay = 1'b0; e = 0; end
      else if (s) begin mplay = 1'b1; e = 0; end
      else if (mplay) e++;
      if (mplay && (e % TD) == 0) latch = mpat[(e / TD) % ST];
      if (we) mpat[wa] = wd;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
  endtask

  initial begin
    logic [15:0] rd;
    mplay = 1'b0; e = 0; latch = 16'd0;
    for (int i = 0; i < ST; i++) mpat[i] = 16'd0;

    // Reset, then load the pattern while idle (must not start playback).
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    check("rst_playing", playing, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, {4'b0001, 12'd440});
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, {4'b1000, 12'd262});
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, {4'b1111, 12'd0});
    for (int a = 3; a < ST; a++) begin
      rd = 16'($urandom);
      rd[11:0] = 12'($urandom_range(1, 4095));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'(a), rd);
    end
    check("idle_write_no_play", playing, 1'b0);

    // Start: first note on the next edge, second step four cycles later.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    check("start_freq", freq, 12'd440);
    check("start_wave", wave_en, 4'b0001);
    check("start_pulse", step_pulse, 1'b1);
    idle(TD);
    check("step1_freq", freq, 12'd262);
    check("step1_wave", wave_en, 4'b1000);
    // Rewrite the step now playing; output must hold until it is next entered.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, {4'b0010, 12'd777});
    check("inflight_hold", freq, 12'd262);

    // Play through all steps to the wrap; step 2 is a rest with all waves set.
    for (int n = 0; n < 200 && e < ST * TD; n++) begin
      idle(1);
      if ((e / TD) % ST == 2) begin
        check("rest2_freq", freq, 12'd0);
        check("rest2_wave", wave_en, 4'd0);
      end
      if (e == (ST - 1) * TD) check("last_step", step_idx, 3'd7);
    end
    check("wrap_step", step_idx, 3'd0);
    check("wrap_pulse", step_pulse, 1'b1);
    check("wrap_reached", e, ST * TD);
    idle(TD);
    check("rewritten_step1", freq, 12'd777);

    // Random writes during playback, then a mid-step restart.
    for (int n = 0; n < 40; n++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd[11:0] = 12'd0;
      cyc(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, ST - 1)), rd);
    end
    idle(2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    check("restart_step", step_idx, 3'd0);
    idle(6);

    // Start and stop together: stop wins.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
    check("ss_playing", playing, 1'b0);
    check("ss_freq", freq, 12'd0);
    idle(3);

    // Reset mid-step 5 beats start/write; then everything plays as rests.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int n = 0; n < 100 && e < 5 * TD + 1; n++) idle(1);
    check("at_step5", step_idx, 3'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, {4'b0001, 12'd100});
    check("rst_freq", freq, 12'd0);
    check("rst_wave", wave_en, 4'd0);
    check("rst_step", step_idx, 3'd0);
    check("rst_pulse", step_pulse, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int n = 0; n < 3 * TD; n++) begin
      idle(1);
      check("allrest_freq", freq, 12'd0);
    end

    // Random control and writes.
    for (int n = 0; n < 120; n++) begin
      rd = 16'($urandom);
      cyc(1'b1, 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, ST - 1)), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
- REQ-001: The block SHALL have parameter STEPS, default 8, giving the number of pattern steps (power of two, 2..16).
- REQ-002: The block SHALL have parameter TICK_DIV, default 25000000, giving the clk cycles per step (minimum 4).
- REQ-003: The block SHALL have parameter GAP_CYC, default 1024, giving the silent cycles at the end of each step (used only under SEQ_GAP_EN; SHALL be less than TICK_DIV).
- REQ-004: The block SHALL have port clk, input, 1 bit: the system clock; the block uses this one clock only.
- REQ-005: The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-006: The block SHALL have port start, input, 1 bit: single-cycle pulse that starts or restarts playback at step 0.
- REQ-007: The block SHALL have port stop, input, 1 bit: single-cycle pulse that halts playback.
- REQ-008: The block SHALL have port wr_en, input, 1 bit: pattern write strobe.
- REQ-009: The block SHALL have port wr_addr, input, log2(STEPS) bits: index of the step to write.
- REQ-010: The block SHALL have port wr_freq, input, 12 bits: note frequency code for the step; 0 means rest.
- REQ-011: The block SHALL have port wr_wave, input, 4 bits: waveform enables for the step (bit0 square, bit1 saw, bit2 triangle, bit3 sine).
- REQ-012: The block SHALL have port freq, output, 12 bits: frequency code driven to the oscillators.
- REQ-013: The block SHALL have port wave_en, output, 4 bits: waveform enables driven to the signal adder.
- REQ-014: The block SHALL have port step_idx, output, log2(STEPS) bits: index of the current step.
- REQ-015: The block SHALL have port playing, output, 1 bit: high while the block is in PLAY or GAP.
- REQ-016: The block SHALL have port step_pulse, output, 1 bit: one-cycle strobe on every step entry.

Function
- REQ-017: The state machine SHALL have states IDLE, PLAY and GAP; GAP exists only under SEQ_GAP_EN.
- REQ-018: The pattern SHALL be held in STEPS registers of 16 bits each ({wave, freq}).
- REQ-019: A write with wr_en high SHALL update pattern[wr_addr] on the next edge, in any state.
- REQ-020: A write to the step currently playing SHALL NOT change freq or wave_en until that step is next entered.
- REQ-021: In IDLE, start SHALL, on the next edge, set state to PLAY, step_idx to 0 and tick counter to 0, load freq/wave_en from pattern[0], and pulse step_pulse.
- REQ-022: In PLAY or GAP, start SHALL restart at step 0 with the same behaviour as REQ-021.
- REQ-023: stop SHALL return the block to IDLE on the next edge with freq=0, wave_en=0, step_idx=0 and playing=0.
- REQ-024: When start and stop are asserted in the same cycle, stop SHALL win.
- REQ-025: The tick counter SHALL count 0..TICK_DIV-1; at the terminal count it SHALL reset to 0, advance step_idx (wrapping STEPS-1 to 0), reload the outputs from the new step, and pulse step_pulse.
- REQ-026: When a step's freq field is 0, the block SHALL output freq=0 and wave_en=0 for that step, regardless of the stored wave field.
- REQ-027: All outputs SHALL be registered; output latency from a step boundary SHALL be zero cycles, with outputs changing on the same edge as step_idx.
- REQ-028: In IDLE the block SHALL hold freq=0, wave_en=0 and step_pulse=0, and a write SHALL NOT start playback.

Reset
- REQ-029: With rst_n low at an edge, the block SHALL set state to IDLE; tick counter, step_idx, freq, wave_en, playing and step_pulse to 0; and all pattern registers to 0 (all rests).
- REQ-030: Reset SHALL take priority over start, stop and wr_en, including during playback.

Configuration
- REQ-031: With SEQ_GAP_EN defined, when the tick counter reaches TICK_DIV-GAP_CYC the block SHALL enter GAP, forcing freq=0 and wave_en=0 until the step boundary, then re-enter PLAY with the next step's values.
- REQ-032: Without SEQ_GAP_EN, the GAP state and GAP_CYC logic SHALL be absent, and notes SHALL play for the full TICK_DIV cycles.

Verification (TICK_DIV=4, GAP_CYC=1, STEPS=8)
- REQ-033: The bench SHALL cover: reset, write pattern[0]={4'b0001,12'd440} and pattern[1]={4'b1000,12'd262}, pulse start -> next cycle freq=440, wave_en=0001, step_pulse=1; 4 cycles later freq=262, wave_en=1000.
- REQ-034: The bench SHALL cover: play through all 8 steps -> step_idx sequence 0..7,0 with step_pulse every 4 cycles, and the wrap to 0 after step 7.
- REQ-035: The bench SHALL cover: write pattern[2]={4'b1111,12'd0} -> freq=0 and wave_en=0 throughout step 2.
- REQ-036: The bench SHALL cover: assert start and stop in the same cycle while in PLAY -> IDLE, playing=0, freq=0 on the next cycle.
- REQ-037: The bench SHALL cover: drive rst_n low mid-step 5 -> all outputs 0 on the next edge, and a subsequent start plays all-rest steps (freq=0).
- REQ-038: The bench SHALL cover, with SEQ_GAP_EN: on the last cycle of each step, freq=0 and wave_en=0, then the next step's values appear on the boundary edge.
